// File: rtl/paddle_bbox_tracker_pkg.sv
// paddle_bbox_tracker_pkg: shared geometry defaults, FSM state enum and bbox report struct
package paddle_bbox_tracker_pkg;
  localparam int DEF_LINE_WIDTH = 640;
  localparam int DEF_FRAME_HEIGHT = 480;
  localparam int DEF_O_PIXEL_DEPTH = 12;
  localparam int DEF_HIT_THRESHOLD = 'hfff;
  localparam int DEF_MIN_ROW_HITS = 4;
  localparam int DEF_X_W = $clog2(DEF_LINE_WIDTH);
  localparam int DEF_Y_W = $clog2(DEF_FRAME_HEIGHT);
  typedef enum logic {WAIT_SOF, SCAN} state_t;
  typedef struct packed {
    logic found;
    logic [DEF_X_W-1:0] x_min;
    logic [DEF_X_W-1:0] x_max;
    logic [DEF_Y_W-1:0] y_min;
    logic [DEF_Y_W-1:0] y_max;
  } bbox_t;
endpackage

// File: rtl/paddle_bbox_tracker_if.sv
// paddle_bbox_tracker_if: edge pixel stream in (valid_i/sof_i/pixel_i) and bbox report out (bbox_valid_o/found_o/x_*/y_*)
interface paddle_bbox_tracker_if #(parameter int O_PIXEL_DEPTH = 12, parameter int X_W = 10, parameter int Y_W = 9);
  logic valid_i;
  logic sof_i;
  logic [O_PIXEL_DEPTH-1:0] pixel_i;
  logic bbox_valid_o;
  logic found_o;
  logic [X_W-1:0] x_min_o;
  logic [X_W-1:0] x_max_o;
  logic [Y_W-1:0] y_min_o;
  logic [Y_W-1:0] y_max_o;
  modport master(output valid_i, sof_i, pixel_i, input bbox_valid_o, found_o, x_min_o, x_max_o, y_min_o, y_max_o);
  modport slave(input valid_i, sof_i, pixel_i, output bbox_valid_o, found_o, x_min_o, x_max_o, y_min_o, y_max_o);
endinterface

// File: rtl/paddle_bbox_tracker_row_span.sv
// row_span_tracker: per-row hit span; min_x/max_x/hits include the current pixel (restart drops prior state, clr empties after it)
module row_span_tracker #(
  parameter int X_W = 10,
  parameter int MIN_ROW_HITS = 4,
  localparam int H_W = $clog2(MIN_ROW_HITS + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  input  logic clr,
  input  logic hit,
  input  logic [X_W-1:0] x,
  output logic [X_W-1:0] min_x,
  output logic [X_W-1:0] max_x,
  output logic [H_W-1:0] hits
);
  logic [X_W-1:0] min_q, max_q, b_min, b_max;
  logic [H_W-1:0] hits_q, b_hits;
  assign b_min = restart ? '1 : min_q;
  assign b_max = restart ? '0 : max_q;
  assign b_hits = restart ? '0 : hits_q;
  assign min_x = hit && x < b_min ? x : b_min;
  assign max_x = hit && x > b_max ? x : b_max;
  assign hits = hit && b_hits != H_W'(MIN_ROW_HITS) ? b_hits + 1'b1 : b_hits;
  always_ff @(posedge clk) begin
    if (reset || (en && clr)) begin
      min_q <= '1;
      max_q <= '0;
      hits_q <= '0;
    end else if (en) begin
      min_q <= min_x;
      max_q <= max_x;
      hits_q <= hits;
    end
  end
endmodule

// File: rtl/paddle_bbox_tracker.sv
// paddle_bbox_tracker: raster edge stream -> per-frame paddle bbox report (clk, reset, bus: slave stream in / report out)
module paddle_bbox_tracker
  import paddle_bbox_tracker_pkg::*;
#(
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
  parameter int O_PIXEL_DEPTH = DEF_O_PIXEL_DEPTH,
  parameter int HIT_THRESHOLD = DEF_HIT_THRESHOLD,
  parameter int MIN_ROW_HITS = DEF_MIN_ROW_HITS,
  localparam int X_W = $clog2(LINE_WIDTH),
  localparam int Y_W = $clog2(FRAME_HEIGHT),
  localparam int H_W = $clog2(MIN_ROW_HITS + 1)
) (
  input logic clk,
  input logic reset,
  paddle_bbox_tracker_if.slave bus
);
  typedef struct packed {
    logic found;
    logic [X_W-1:0] x_min;
    logic [X_W-1:0] x_max;
    logic [Y_W-1:0] y_min;
    logic [Y_W-1:0] y_max;
  } box_t;
  localparam box_t EMPTY = '{found: 1'b0, x_min: '1, x_max: '0, y_min: '0, y_max: '0};
  state_t state, state_nx;
  logic proc, restart, hit, row_end, frame_end, commit, pulse_q;
  logic [X_W-1:0] x_q, px, row_min, row_max;
  logic [Y_W-1:0] y_q, py;
  logic [H_W-1:0] row_hits;
  box_t acc_q, acc_base, acc_nx, out_q;
  always_ff @(posedge clk) state <= reset ? WAIT_SOF : state_nx;
  // Any accepted sof_i re-anchors the frame at (0,0); at the expected origin this is a no-op.
  always_comb begin
    restart = bus.valid_i && bus.sof_i;
    proc = bus.valid_i && (state == SCAN || bus.sof_i);
    state_nx = restart ? SCAN : state;
  end
  assign px = restart ? '0 : x_q;
  assign py = restart ? '0 : y_q;
  assign hit = bus.pixel_i >= O_PIXEL_DEPTH'(HIT_THRESHOLD);
  assign row_end = px == X_W'(LINE_WIDTH - 1);
  assign frame_end = row_end && py == Y_W'(FRAME_HEIGHT - 1);
  assign commit = row_end && row_hits >= H_W'(MIN_ROW_HITS);
  assign acc_base = restart ? EMPTY : acc_q;
  row_span_tracker #(.X_W(X_W), .MIN_ROW_HITS(MIN_ROW_HITS)) u_row (
    .clk(clk), .reset(reset), .en(proc), .restart(restart), .clr(row_end), .hit(hit), .x(px),
    .min_x(row_min), .max_x(row_max), .hits(row_hits)
  );
  always_comb begin
    acc_nx.found = acc_base.found || commit;
    acc_nx.x_min = commit && row_min < acc_base.x_min ? row_min : acc_base.x_min;
    acc_nx.x_max = commit && row_max > acc_base.x_max ? row_max : acc_base.x_max;
    acc_nx.y_min = commit && !acc_base.found ? py : acc_base.y_min;
    acc_nx.y_max = commit ? py : acc_base.y_max;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
      acc_q <= EMPTY;
      out_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= proc && frame_end;
      if (proc) begin
        x_q <= row_end ? '0 : px + 1'b1;
        y_q <= frame_end ? '0 : py + Y_W'(row_end);
        acc_q <= frame_end ? EMPTY : acc_nx;
        if (frame_end) out_q <= acc_nx.found ? acc_nx : '0;
      end
    end
  end
  assign bus.bbox_valid_o = pulse_q;
  assign bus.found_o = out_q.found;
  assign bus.x_min_o = out_q.x_min;
  assign bus.x_max_o = out_q.x_max;
  assign bus.y_min_o = out_q.y_min;
  assign bus.y_max_o = out_q.y_max;
endmodule
